// File: rtl/mux_arb_pkg.sv
// rtl/mux_arb_pkg.sv - shared types and defaults for the two-requester mux arbiter
//
// Purpose: FSM state and owner encodings plus default parameter values used by
//          the arbiter interface, top and bench.
// Ports:   none (package).

package mux_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_A = 2'd1,
        OWN_B = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWNER_A = 1'b0,
        OWNER_B = 1'b1
    } owner_t;

    localparam int DEFAULT_WIDTH    = 8;
    localparam int DEFAULT_MAX_HOLD = 4;
    localparam int DEFAULT_CNT_W    = 8;

endpackage

// File: rtl/mux_21_arbiter_if.sv
// rtl/mux_21_arbiter_if.sv - request/grant/data bundle between requesters and the arbiter
//
// Purpose: groups both requesters' request and data lines with the arbiter's
//          grant, select and muxed-data outputs.
// Ports (signals):
//   req_a_in, req_b_in : level requests, held for the transaction
//   a_in, b_in         : requester data, WIDTH bits
//   gnt_a_out, gnt_b_out, sel_out : registered-state decodes from the arbiter
//   y_out, valid_out   : selected data and its qualifier
// Modports: master = requester side, slave = arbiter side.

interface mux_21_arbiter_if #(
    parameter int WIDTH = mux_arb_pkg::DEFAULT_WIDTH
);
    logic             req_a_in;
    logic             req_b_in;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             gnt_a_out;
    logic             gnt_b_out;
    logic             sel_out;
    logic [WIDTH-1:0] y_out;
    logic             valid_out;

    modport master (
        output req_a_in, req_b_in, a_in, b_in,
        input  gnt_a_out, gnt_b_out, sel_out, y_out, valid_out
    );

    modport slave (
        input  req_a_in, req_b_in, a_in, b_in,
        output gnt_a_out, gnt_b_out, sel_out, y_out, valid_out
    );
endinterface

// File: rtl/mux_21.sv
// rtl/mux_21.sv - 1-bit 2:1 multiplexer cell
//
// Purpose: basic datapath cell, y = sel ? b : a.
// Ports:
//   a, b : data inputs
//   sel  : 0 selects a, 1 selects b
//   y    : selected bit

module mux_21 (
    input  logic a,
    input  logic b,
    input  logic sel,
    output logic y
);
    assign y = sel ? b : a;
endmodule

// File: rtl/mux_21_arbiter.sv
// rtl/mux_21_arbiter.sv - round-robin arbiter owning a shared 2:1 datapath mux
//
// Purpose: grants the shared path to requester A or B, alternating on
//          contention, with an optional hold limit that hands the path over
//          when the owner has held it MAX_HOLD cycles and the other side waits.
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : mux_21_arbiter_if.slave (requests/data in; grants, sel, y, valid out)
// Parameters: WIDTH data width, MAX_HOLD hold limit (0 = never preempt),
//             CNT_W hold counter width (MAX_HOLD <= 2**CNT_W-1).

module mux_21_arbiter
    import mux_arb_pkg::*;
#(
    parameter int WIDTH    = DEFAULT_WIDTH,
    parameter int MAX_HOLD = DEFAULT_MAX_HOLD,
    parameter int CNT_W    = DEFAULT_CNT_W
) (
    input  logic                 clk,
    input  logic                 rst,
    mux_21_arbiter_if.slave      bus
);

    // Counter value at which an owner becomes preemptible; with MAX_HOLD = 0
    // the counter just sits at zero and preemption is disabled.
    localparam bit             PREEMPT_EN = (MAX_HOLD != 0);
    localparam logic [CNT_W-1:0] HOLD_LAST =
        PREEMPT_EN ? CNT_W'(MAX_HOLD - 1) : '0;

    arb_state_t       state_q;
    arb_state_t       state_d;
    logic [CNT_W-1:0] hold_cnt_q;
    owner_t           last_owner_q;

    logic             req_a;
    logic             req_b;
    logic             hold_expired;
    logic             gnt_a;
    logic             gnt_b;
    logic             sel;
    logic [WIDTH-1:0] a_data;
    logic [WIDTH-1:0] b_data;
    logic [WIDTH-1:0] y_data;

    assign req_a        = bus.req_a_in;
    assign req_b        = bus.req_b_in;
    assign a_data       = bus.a_in;
    assign b_data       = bus.b_in;
    assign hold_expired = PREEMPT_EN && (hold_cnt_q == HOLD_LAST);

    // State, hold counter and round-robin pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            hold_cnt_q   <= '0;
            last_owner_q <= OWNER_B;   // A wins the first contention
        end else begin
            state_q <= state_d;

            // Any state change is either an entry into an owner state or a
            // return to IDLE; both restart the hold count.
            if ((state_d != state_q) || (state_d == IDLE)) begin
                hold_cnt_q <= '0;
            end else if (hold_cnt_q != HOLD_LAST) begin
                hold_cnt_q <= hold_cnt_q + 1'b1;
            end

            if ((state_d == OWN_A) && (state_q != OWN_A)) begin
                last_owner_q <= OWNER_A;
            end else if ((state_d == OWN_B) && (state_q != OWN_B)) begin
                last_owner_q <= OWNER_B;
            end
        end
    end

    // Next-state selection.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (req_a && req_b) begin
                    state_d = (last_owner_q == OWNER_A) ? OWN_B : OWN_A;
                end else if (req_a) begin
                    state_d = OWN_A;
                end else if (req_b) begin
                    state_d = OWN_B;
                end
            end
            OWN_A: begin
                // Release goes straight to the waiting side, no idle bubble.
                if (!req_a) begin
                    state_d = req_b ? OWN_B : IDLE;
                end else if (hold_expired && req_b) begin
                    state_d = OWN_B;
                end
            end
            OWN_B: begin
                if (!req_b) begin
                    state_d = req_a ? OWN_A : IDLE;
                end else if (hold_expired && req_a) begin
                    state_d = OWN_A;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs decode registered state only, so reset clears them immediately
    // and there is no request-to-grant combinational path.
    always_comb begin
        gnt_a = (state_q == OWN_A);
        gnt_b = (state_q == OWN_B);
        sel   = (state_q == OWN_B);
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_mux
        mux_21 u_mux (
            .a   (a_data[i]),
            .b   (b_data[i]),
            .sel (sel),
            .y   (y_data[i])
        );
    end

    assign bus.gnt_a_out = gnt_a;
    assign bus.gnt_b_out = gnt_b;
    assign bus.sel_out   = sel;
    assign bus.valid_out = gnt_a | gnt_b;
    assign bus.y_out     = y_data;

endmodule

// File: doc/mux_21_arbiter.md
Name: mux_21_arbiter

Overview:
- Two-requester round-robin arbiter that owns the select of a shared 2:1 datapath mux.
- Requester A and requester B each raise a request and hold it for the length of their transaction.
- The arbiter registers a grant, drives the mux select, and forwards the selected requester's data with a valid qualifier.
- Optional hold limit: preempts an owner that has held the path too long while the other side is waiting.

Parameters:
- WIDTH, 8, data width of each requester's data bus and of y_out.
- MAX_HOLD, 4, maximum consecutive owned cycles before forced hand-over when the other requester is waiting; 0 = never preempt.
- CNT_W, 8, hold counter width; MAX_HOLD must be ≤ 2^CNT_W−1.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_a_in  input  1  requester A request, level, held for duration of transaction.
- req_b_in  input  1  requester B request.
- a_in  input  WIDTH  requester A data.
- b_in  input  WIDTH  requester B data.
- gnt_a_out  output  1  grant to A, registered.
- gnt_b_out  output  1  grant to B, registered.
- sel_out  output  1  mux select: 0 = A, 1 = B, registered.
- y_out  output  WIDTH  selected data, combinational from sel_out.
- valid_out  output  1  high when y_out carries a granted requester's data (gnt_a_out | gnt_b_out).

Behaviour:
- One clock (clk); reset is asynchronous and active-high (rst).
- Reset (asserted at any time, including mid-transaction) takes effect immediately, without waiting for a clock edge:
  - state = IDLE; gnt_a_out = 0, gnt_b_out = 0, sel_out = 0, valid_out = 0.
  - hold_cnt = 0; last_owner = B, so A wins the first contention.
  - y_out = a_in.
- States: IDLE, OWN_A, OWN_B. All transitions occur on the rising clk edge. Outputs are decoded from registered state only; no combinational req→gnt path.
- Grant latency: request sampled high at edge N gives grant high after edge N (visible in cycle N+1).
- IDLE:
  - Only req_a → OWN_A.
  - Only req_b → OWN_B.
  - Both → the side that is not last_owner.
  - Neither → stay IDLE.
- OWN_A (OWN_B is symmetric):
  - req_a_in low → release. Go to OWN_B if req_b_in is high (no idle bubble), else IDLE.
  - MAX_HOLD ≠ 0, hold_cnt == MAX_HOLD−1, req_b_in high → preempt to OWN_B, even though req_a_in is still high.
  - Otherwise stay; hold_cnt increments.
- hold_cnt:
  - Cleared on every entry into OWN_A or OWN_B and in IDLE.
  - Saturates at MAX_HOLD−1 when there is no competitor. The owner keeps the path indefinitely while uncontested.
- last_owner updates on every entry into OWN_A/OWN_B.
- Grant outputs: gnt_a_out = (state == OWN_A); gnt_b_out = (state == OWN_B); the two are never both high.
- sel_out: 1 only in OWN_B; 0 in IDLE and OWN_A.
- Hand-over A→B is one edge: gnt_a_out falls and gnt_b_out rises in the same cycle; valid_out stays high.
- Requester dropping req: allowed any cycle. The arbiter releases at the next edge; data in that final cycle is still marked valid.
- Request re-asserted by the previous owner while the other side is waiting → waits its turn (round-robin).
- A preempted requester keeps req high; it is regranted after the other side releases or is itself preempted.

Decomposition:
- Shared package mux_arb_pkg:
  - typedef enum logic [1:0] {IDLE, OWN_A, OWN_B} arb_state_t.
  - typedef enum logic {OWNER_A, OWNER_B} owner_t.
  - localparam defaults for WIDTH and MAX_HOLD.
- Datapath: generate loop of WIDTH instances of the team's existing 1-bit mux_21 cell, sel driven by sel_out.
- FSM, counter and round-robin pointer in the top module.

Test Plan:
- Reset mid-grant: A owns, assert rst between edges → gnt_a_out, valid_out and sel_out drop immediately without a clock edge. After release, req_b alone → gnt_b_out at the next edge.
- Single requester: req_a_in = 1 for 3 cycles, a_in = 8'h5A →
  - gnt_a_out high for 3 cycles starting one cycle after the request.
  - y_out = 8'h5A and valid_out = 1 while granted.
  - IDLE after req_a_in drops.
- Simultaneous first requests: req_a_in = req_b_in = 1 from reset → A granted first.
  - MAX_HOLD = 4: A owns 4 cycles, then gnt_b_out = 1, sel_out = 1, y_out = b_in, with no IDLE cycle between.
- Uncontested long hold: req_a_in = 1 for 20 cycles, req_b_in = 0 → gnt_a_out stays high all 20 cycles; no preemption.
- Back-to-back release: B owns; req_b_in drops while req_a_in = 1 → the next edge gives gnt_a_out = 1, sel_out = 0, valid_out continuously high.
- MAX_HOLD = 0 with both requesting: A keeps the grant until req_a_in drops (e.g. 10 cycles), then B is granted next cycle. Checker asserts gnt_a_out & gnt_b_out is never 1.
